// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs R/I/S/B fields into a 32-bit word, flags immediates
// that do not fit the format, and queues words for an instruction-memory writer.
module instr_encoder #(
    parameter int unsigned         DEPTH     = 2,
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        fmt_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       instr_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        err_cnt_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_S = 2'd2,
        FMT_B = 2'd3
    } fmt_e;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        err_cnt_q;

    logic        push;
    logic        pop;
    logic        fits_12;
    logic        fits_13;
    logic [31:0] enc_word;
    logic        enc_err;

    // ready_o looks only at occupancy, so a full FIFO never takes a push even while popping.
    assign ready_o = (count != CNT_W'(DEPTH));
    assign valid_o = (count != '0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    // A value fits N signed bits when everything above bit N-2 is pure sign extension.
    assign fits_12 = (&imm_i[31:11]) || !(|imm_i[31:11]);
    assign fits_13 = (&imm_i[31:12]) || !(|imm_i[31:12]);

    // NOTE: every output of this block gets a value before the case, so no path leaves
    // enc_word/enc_err unassigned and no latch is inferred.
    always_comb begin
        enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        enc_err  = 1'b0;
        case (fmt_e'(fmt_i))
            FMT_I: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                enc_err  = !fits_12;
            end
            FMT_S: begin
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                enc_err  = !fits_12;
            end
            FMT_B: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
                enc_err  = !fits_13 || imm_i[0];
            end
            default: ;
        endcase
    end

    // NOTE: the storage array is cleared on reset (it is only DEPTH entries) so the head
    // reads as zero straight out of reset; sequential state uses non-blocking assignments.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            addr_q    <= BASE_ADDR;
            err_cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{err: enc_err, instr: enc_word};
                wr_ptr      <= wr_ptr + PTR_W'(1);
                if (enc_err && (err_cnt_q != 8'hFF)) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                addr_q <= addr_q + ADDR_W'(4);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign instr_o   = mem[rd_ptr].instr;
    assign err_o     = mem[rd_ptr].err;
    assign addr_o    = addr_q;
    assign err_cnt_o = err_cnt_q;

endmodule
